// File: rtl/dc_ctrl.sv
// Byte-serial data-cache controller: splits store/load-buffer requests of 1, 2 or 4 bytes
// into single-byte memory accesses and returns extended load results tagged with the ROB nickname.
module dc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        iSLB_en,
  input  logic        iSLB_ls,
  input  logic [3:0]  iSLB_nick,
  input  logic [2:0]  iSLB_len,
  input  logic        iSLB_sext,
  input  logic [31:0] iSLB_addr,
  input  logic [31:0] iSLB_dt,
  output logic        oSLB_busy,
  output logic        oDC_en,
  output logic [3:0]  oDC_nick,
  output logic [31:0] oDC_dt,
  input  logic        iMEM_stall,
  input  logic [7:0]  iMEM_din,
  output logic [31:0] oMEM_a,
  output logic [7:0]  oMEM_dout,
  output logic        oMEM_wr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [2:0]  len_r;
  logic        sext_r;
  logic [3:0]  nick_r;
  logic [31:0] dt_r;
  logic [31:0] result_r;
  logic        pend_r;
  logic [1:0]  pend_idx_r;
  logic [31:0] mem_a_r;
  logic [7:0]  mem_dout_r;
  logic [3:0]  dc_nick_r;
  logic [31:0] dc_dt_r;

  logic        active_s;
  logic        issue_s;
  logic        last_cap_s;
  logic [31:0] res_next_s;

  // Anything other than 1 or 2 is handled as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    logic [2:0] n;
    case (len)
      3'd1:    n = 3'd1;
      3'd2:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [2:0] len,
                                         input logic sext);
    logic [31:0] v;
    case (len)
      3'd1:    v = {{24{sext & r[7]}}, r[7:0]};
      3'd2:    v = {{16{sext & r[15]}}, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] r, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] v;
    v = r;
    case (idx)
      2'd0:    v[7:0]   = b;
      2'd1:    v[15:8]  = b;
      2'd2:    v[23:16] = b;
      default: v[31:24] = b;
    endcase
    return v;
  endfunction

  // Issue qualification and the load result including the byte arriving this cycle.
  always_comb begin
    active_s   = (state_r == LOAD) || (state_r == STORE);
    issue_s    = rdy && !rst && !iMEM_stall && active_s && (cnt_r < len_r);
    last_cap_s = pend_r && ({1'b0, pend_idx_r} == (len_r - 3'd1));
    if (pend_r) begin
      res_next_s = put_byte(result_r, pend_idx_r, iMEM_din);
    end else begin
      res_next_s = result_r;
    end
  end

  // Controller FSM with byte counter, capture pipeline and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      len_r      <= 3'd0;
      sext_r     <= 1'b0;
      nick_r     <= 4'd0;
      dt_r       <= 32'd0;
      result_r   <= 32'd0;
      pend_r     <= 1'b0;
      pend_idx_r <= 2'd0;
      mem_a_r    <= 32'd0;
      mem_dout_r <= 8'd0;
      dc_nick_r  <= 4'd0;
      dc_dt_r    <= 32'd0;
    end else if (rdy) begin
      case (state_r)
        IDLE: begin
          // A flushed load never starts; a store already committed proceeds.
          if (iSLB_en && (iSLB_ls || !clr)) begin
            state_r    <= iSLB_ls ? STORE : LOAD;
            cnt_r      <= 3'd0;
            len_r      <= norm_len(iSLB_len);
            sext_r     <= iSLB_sext;
            nick_r     <= iSLB_nick;
            dt_r       <= iSLB_dt;
            result_r   <= 32'd0;
            pend_r     <= 1'b0;
            mem_a_r    <= iSLB_addr;
            mem_dout_r <= iSLB_dt[7:0];
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (clr) begin
            state_r <= IDLE;
            pend_r  <= 1'b0;
          end else begin
            pend_r <= issue_s;
            if (issue_s) begin
              cnt_r      <= cnt_r + 3'd1;
              pend_idx_r <= cnt_r[1:0];
              if ((cnt_r + 3'd1) != len_r) begin
                mem_a_r <= mem_a_r + 32'd1;
              end
            end
            if (pend_r) begin
              result_r <= res_next_s;
            end
            if (last_cap_s) begin
              state_r   <= DONE;
              dc_nick_r <= nick_r;
              dc_dt_r   <= extend(res_next_s, len_r, sext_r);
            end
          end
        end
        STORE: begin
          if (issue_s) begin
            cnt_r <= cnt_r + 3'd1;
            if ((cnt_r + 3'd1) == len_r) begin
              state_r <= IDLE;
            end else begin
              mem_a_r    <= mem_a_r + 32'd1;
              mem_dout_r <= dt_r[15:8];
              dt_r       <= dt_r >> 8;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // The completion pulse is withheld while stalled by rdy or flushed.
  assign oSLB_busy = (state_r != IDLE);
  assign oDC_en    = (state_r == DONE) && rdy && !clr && !rst;
  assign oDC_nick  = dc_nick_r;
  assign oDC_dt    = dc_dt_r;
  assign oMEM_a    = mem_a_r;
  assign oMEM_dout = mem_dout_r;
  assign oMEM_wr   = issue_s && (state_r == STORE);

endmodule

// File: tb/tb_dc_ctrl.sv
// Self-checking bench for dc_ctrl: directed scenarios plus randomized traffic against
// a transaction-level model (expected write stream, expected load results, busy window).
module tb_dc_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        iSLB_en;
  logic        iSLB_ls;
  logic [3:0]  iSLB_nick;
  logic [2:0]  iSLB_len;
  logic        iSLB_sext;
  logic [31:0] iSLB_addr;
  logic [31:0] iSLB_dt;
  logic        oSLB_busy;
  logic        oDC_en;
  logic [3:0]  oDC_nick;
  logic [31:0] oDC_dt;
  logic        iMEM_stall;
  logic [7:0]  iMEM_din;
  logic [31:0] oMEM_a;
  logic [7:0]  oMEM_dout;
  logic        oMEM_wr;

  dc_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iSLB_en(iSLB_en), .iSLB_ls(iSLB_ls), .iSLB_nick(iSLB_nick), .iSLB_len(iSLB_len),
    .iSLB_sext(iSLB_sext), .iSLB_addr(iSLB_addr), .iSLB_dt(iSLB_dt),
    .oSLB_busy(oSLB_busy), .oDC_en(oDC_en), .oDC_nick(oDC_nick), .oDC_dt(oDC_dt),
    .iMEM_stall(iMEM_stall), .iMEM_din(iMEM_din), .oMEM_a(oMEM_a),
    .oMEM_dout(oMEM_dout), .oMEM_wr(oMEM_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte memory: written locations tracked, others hold a fixed address hash.
  logic [7:0] wmem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic int eff_len(input logic [2:0] len);
    return (len == 3'd1) ? 1 : ((len == 3'd2) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] len,
                                           input logic sext);
    int n;
    logic [31:0] v;
    n = eff_len(len);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_rd(a + 32'(k))) << (8 * k));
    if (sext && v[8*n-1] && n < 4) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst && rdy && !iMEM_stall) begin
      if (oMEM_wr) wmem[oMEM_a] = oMEM_dout;
      else iMEM_din <= mem_rd(oMEM_a);
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         wq[$];
  wr_t         e;
  logic        ld_out = 1'b0;
  int          ld_age;
  logic [3:0]  exp_nick;
  logic [31:0] exp_dt;
  logic        model_busy;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          en_cyc = 0;
  int          idle_cyc = 0;
  logic        wait_idle = 1'b0;
  int          wr_count = 0;
  int          en_count = 0;
  logic [3:0]  en_nick;
  logic [31:0] en_dt;

  // Monitor: compares the observed write stream, completions and busy window to the model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      wq.delete();
      ld_out    = 1'b0;
      wait_idle = 1'b0;
    end else begin
      model_busy = (wq.size() != 0) || ld_out;
      check("busy", {31'd0, oSLB_busy}, {31'd0, model_busy});
      if (wait_idle && !oSLB_busy) begin
        idle_cyc  = cyc;
        wait_idle = 1'b0;
      end
      if (oMEM_wr) begin
        wr_count++;
        if (wq.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = wq.pop_front();
          check("wr_addr", oMEM_a, e.a);
          check("wr_data", {24'd0, oMEM_dout}, {24'd0, e.d});
        end
      end
      if (oDC_en) begin
        en_count++;
        en_cyc  = cyc;
        en_nick = oDC_nick;
        en_dt   = oDC_dt;
        if (!ld_out) begin
          check("en_unexpected", 32'd1, 32'd0);
        end else begin
          check("ld_nick", {28'd0, oDC_nick}, {28'd0, exp_nick});
          check("ld_data", oDC_dt, exp_dt);
          ld_out = 1'b0;
        end
      end else if (ld_out && rdy && clr) begin
        ld_out = 1'b0;
      end
      if (ld_out) begin
        ld_age++;
        if (ld_age > 80) begin
          check("ld_timeout", 32'd0, 32'd1);
          ld_out = 1'b0;
        end
      end
      if (iSLB_en && rdy && !model_busy) begin
        acc_cyc   = cyc;
        wait_idle = 1'b1;
        if (iSLB_ls) begin
          for (int k = 0; k < eff_len(iSLB_len); k++) begin
            e.a = iSLB_addr + 32'(k);
            e.d = iSLB_dt[8*k +: 8];
            wq.push_back(e);
          end
        end else if (!clr) begin
          ld_out   = 1'b1;
          ld_age   = 0;
          exp_nick = iSLB_nick;
          exp_dt   = ref_load(iSLB_addr, iSLB_len, iSLB_sext);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic ls, input logic [3:0] nick, input logic [2:0] len,
                        input logic sext, input logic [31:0] addr, input logic [31:0] dt,
                        input logic c);
    iSLB_en = 1'b1; iSLB_ls = ls; iSLB_nick = nick; iSLB_len = len;
    iSLB_sext = sext; iSLB_addr = addr; iSLB_dt = dt; clr = c;
    tick();
    iSLB_en = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((oSLB_busy || ld_out || wq.size() != 0) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) check("settle_timeout", 32'd0, 32'd1);
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, oSLB_busy}, 32'd0);
    check({tag, "_en"}, {31'd0, oDC_en}, 32'd0);
    check({tag, "_nick"}, {28'd0, oDC_nick}, 32'd0);
    check({tag, "_dt"}, oDC_dt, 32'd0);
    check({tag, "_a"}, oMEM_a, 32'd0);
    check({tag, "_dout"}, {24'd0, oMEM_dout}, 32'd0);
    check({tag, "_wr"}, {31'd0, oMEM_wr}, 32'd0);
  endtask

  int c0;
  int w0;

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; iMEM_stall = 1'b0; iMEM_din = 8'd0;
    iSLB_en = 1'b0; iSLB_ls = 1'b0; iSLB_nick = 4'd0; iSLB_len = 3'd4; iSLB_sext = 1'b0;
    iSLB_addr = 32'd0; iSLB_dt = 32'd0;
    wmem[32'h100] = 8'h78; wmem[32'h101] = 8'h56; wmem[32'h102] = 8'h34; wmem[32'h103] = 8'h12;
    wmem[32'h20] = 8'h80;
    tick(); tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
    tick();

    // LW, LB signed / unsigned latencies and data
    do_req(1'b0, 4'd3, 3'd4, 1'b0, 32'h100, 32'd0, 1'b0);
    settle();
    check("lw_lat", 32'(en_cyc - acc_cyc), 32'd6);
    check("lw_nick", {28'd0, en_nick}, 32'd3);
    check("lw_dt", en_dt, 32'h12345678);
    do_req(1'b0, 4'd5, 3'd1, 1'b1, 32'h20, 32'd0, 1'b0);
    settle();
    check("lb_lat", 32'(en_cyc - acc_cyc), 32'd3);
    check("lb_dt", en_dt, 32'hFFFFFF80);
    do_req(1'b0, 4'd6, 3'd1, 1'b0, 32'h20, 32'd0, 1'b0);
    settle();
    check("lbu_dt", en_dt, 32'h00000080);

    // SH: two writes, no completion, idle at len+1
    c0 = en_count; w0 = wr_count;
    do_req(1'b1, 4'd7, 3'd2, 1'b0, 32'h40, 32'hAABBCCDD, 1'b0);
    settle();
    check("sh_writes", 32'(wr_count - w0), 32'd2);
    check("sh_no_en", 32'(en_count - c0), 32'd0);
    check("sh_idle", 32'(idle_cyc - acc_cyc), 32'd3);
    check("sh_m40", {24'd0, mem_rd(32'h40)}, 32'hDD);
    check("sh_m41", {24'd0, mem_rd(32'h41)}, 32'hCC);

    // LW with two stalled cycles mid-access
    do_req(1'b0, 4'd9, 3'd4, 1'b0, 32'h100, 32'd0, 1'b0);
    tick();
    iMEM_stall = 1'b1;
    tick(); tick();
    iMEM_stall = 1'b0;
    settle();
    check("stall_lat", 32'(en_cyc - acc_cyc), 32'd8);
    check("stall_dt", en_dt, 32'h12345678);

    // Flush during LW byte 2 kills it; flush during SW does not
    c0 = en_count;
    do_req(1'b0, 4'd10, 3'd4, 1'b0, 32'h100, 32'd0, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_ld_busy", {31'd0, oSLB_busy}, 32'd0);
    settle();
    check("clr_ld_no_en", 32'(en_count - c0), 32'd0);
    w0 = wr_count;
    do_req(1'b1, 4'd1, 3'd4, 1'b0, 32'h200, 32'h44332211, 1'b1);
    clr = 1'b1;
    repeat (4) tick();
    clr = 1'b0;
    settle();
    check("clr_st_writes", 32'(wr_count - w0), 32'd4);
    check("clr_st_m203", {24'd0, mem_rd(32'h203)}, 32'h44);

    // Flush coincident with a new load drops it; illegal length acts as a word
    c0 = en_count;
    do_req(1'b0, 4'd2, 3'd4, 1'b0, 32'h100, 32'd0, 1'b1);
    settle();
    check("clr_acc_no_en", 32'(en_count - c0), 32'd0);
    do_req(1'b0, 4'd12, 3'd3, 1'b1, 32'h100, 32'd0, 1'b0);
    settle();
    check("len3_lat", 32'(en_cyc - acc_cyc), 32'd6);
    check("len3_dt", en_dt, 32'h12345678);

    // rdy low freezes the pending store byte and suppresses writes
    do_req(1'b1, 4'd4, 3'd4, 1'b0, 32'h500, 32'h11223344, 1'b0);
    tick();
    rdy = 1'b0;
    @(negedge clk);
    check("frz_wr", {31'd0, oMEM_wr}, 32'd0);
    check("frz_a", oMEM_a, 32'h501);
    check("frz_dout", {24'd0, oMEM_dout}, 32'h33);
    tick();
    @(negedge clk);
    check("frz_a2", oMEM_a, 32'h501);
    check("frz_busy", {31'd0, oSLB_busy}, 32'd1);
    tick();
    rdy = 1'b1;
    settle();
    check("frz_m503", {24'd0, mem_rd(32'h503)}, 32'h11);

    // Reset during SW byte 1
    w0 = wr_count;
    do_req(1'b1, 4'd8, 3'd4, 1'b0, 32'h300, 32'hA1B2C3D4, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (6) tick();
    check("midrst_writes", 32'(wr_count - w0), 32'd1);
    check("midrst_m301", {31'd0, wmem.exists(32'h301)}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rdy        = ($urandom_range(9) != 0);
      iMEM_stall = ($urandom_range(3) == 0);
      clr        = ($urandom_range(24) == 0);
      iSLB_en    = ($urandom_range(2) == 0);
      iSLB_ls    = 1'($urandom_range(1));
      iSLB_nick  = 4'($urandom_range(15));
      iSLB_len   = 3'($urandom_range(7));
      iSLB_sext  = 1'($urandom_range(1));
      iSLB_addr  = ($urandom_range(7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(3))) : $urandom();
      iSLB_dt    = $urandom();
      tick();
    end
    iSLB_en = 1'b0; rdy = 1'b1; iMEM_stall = 1'b0; clr = 1'b0;
    repeat (60) tick();
    check("drain_wq", 32'(wq.size()), 32'd0);
    check("drain_ld", {31'd0, ld_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
